// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: encodings, FSM states and decoded-instruction flags for the multicycle controller
package mc_ctrl_pkg;

    localparam logic [1:0] EXT_ZERO    = 2'b00;
    localparam logic [1:0] EXT_SIGNED  = 2'b01;
    localparam logic [1:0] EXT_HIGHPOS = 2'b10;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    localparam logic [1:0] GPRSEL_RD = 2'd0;
    localparam logic [1:0] GPRSEL_RT = 2'd1;
    localparam logic [1:0] GPRSEL_31 = 2'd2;

    localparam logic [1:0] WDSEL_ALU = 2'd0;
    localparam logic [1:0] WDSEL_MEM = 2'd1;
    localparam logic [1:0] WDSEL_PC  = 2'd2;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_JR   = 6'b001000;

    typedef enum logic [2:0] {FETCH, DCD, EXE, MEM, WB} state_e;

    typedef struct packed {
        logic addu;
        logic subu;
        logic andr;
        logic orr;
        logic slt;
        logic jr;
        logic addi;
        logic addiu;
        logic slti;
        logic andi;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
    } insn_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: maps Op/Funct to one-hot instruction flags and flags anything undecodable
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output insn_t      insn,
    output logic       illegal
);

    // one flag per supported instruction; none set means illegal
    always_comb begin
        insn       = '0;
        insn.addu  = Op == OP_R && Funct == F_ADDU;
        insn.subu  = Op == OP_R && Funct == F_SUBU;
        insn.andr  = Op == OP_R && Funct == F_AND;
        insn.orr   = Op == OP_R && Funct == F_OR;
        insn.slt   = Op == OP_R && Funct == F_SLT;
        insn.jr    = Op == OP_R && Funct == F_JR;
        insn.addi  = Op == OP_ADDI;
        insn.addiu = Op == OP_ADDIU;
        insn.slti  = Op == OP_SLTI;
        insn.andi  = Op == OP_ANDI;
        insn.ori   = Op == OP_ORI;
        insn.lui   = Op == OP_LUI;
        insn.lw    = Op == OP_LW;
        insn.sw    = Op == OP_SW;
        insn.beq   = Op == OP_BEQ;
        insn.bne   = Op == OP_BNE;
        insn.j     = Op == OP_J;
        insn.jal   = Op == OP_JAL;
        illegal    = ~|insn;
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle FETCH/DCD/EXE/MEM/WB controller driving datapath selects and write enables
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] EXTOp,
    output logic [2:0] ALUOp,
    output logic       BSel,
    output logic [1:0] NPCOp,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       InsnDone,
    output logic       Illegal
);

    state_e state, next;
    insn_t  d;
    logic   bad, ralu, ialu, mem_op, branch;
    logic   [2:0] alu_d;

    mc_decode u_dec (.Op(Op), .Funct(Funct), .insn(d), .illegal(bad));

    assign ralu   = d.addu | d.subu | d.andr | d.orr | d.slt;
    assign ialu   = d.addi | d.addiu | d.slti | d.andi | d.ori | d.lui;
    assign mem_op = d.lw | d.sw;
    assign branch = d.beq | d.bne;
    assign alu_d  = (d.addu | d.addi | d.addiu | d.lui | mem_op) ? ALU_ADD :
                    (d.subu | branch)                          ? ALU_SUB :
                    (d.andr | d.andi)                          ? ALU_AND :
                    (d.orr | d.ori)                            ? ALU_OR  :
                    (d.slt | d.slti)                           ? ALU_SLT : ALU_NOP;

    // state register; reset parks the FSM in FETCH
    always_ff @(posedge clk)
        state <= rst ? FETCH : next;

    // next-state and per-state datapath controls; ALU/write selects stay stable from EXE to WB
    always_comb begin
        next     = state;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        Illegal  = 1'b0;
        ALUOp    = ALU_NOP;
        BSel     = 1'b0;
        NPCOp    = NPC_PLUS4;
        GPRSel   = GPRSEL_RD;
        WDSel    = WDSEL_ALU;
        EXTOp    = (d.addi | d.addiu | d.slti | mem_op | branch) ? EXT_SIGNED :
                   d.lui ? EXT_HIGHPOS : EXT_ZERO;
        if (state == EXE || state == MEM || state == WB) begin
            ALUOp  = alu_d;
            BSel   = ialu | mem_op;
            GPRSel = ralu ? GPRSEL_RD : GPRSEL_RT;
            WDSel  = d.lw ? WDSEL_MEM : WDSEL_ALU;
        end
        case (state)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                next    = DCD;
            end
            DCD: begin
                if (bad) begin
                    Illegal = 1'b1;
                    next    = FETCH;
                end else if (d.j | d.jal | d.jr) begin
                    PCWrite  = 1'b1;
                    NPCOp    = d.jr ? NPC_JR : NPC_JUMP;
                    RegWrite = d.jal;
                    GPRSel   = d.jal ? GPRSEL_31 : GPRSEL_RD;
                    WDSel    = d.jal ? WDSEL_PC : WDSEL_ALU;
                    next     = FETCH;
                end else
                    next = EXE;
            end
            EXE: begin
                if (branch) begin
                    NPCOp   = NPC_BRANCH;
                    PCWrite = d.beq ? Zero : !Zero;
                    next    = FETCH;
                end else
                    next = mem_op ? MEM : WB;
            end
            MEM: begin
                MemWrite = d.sw;
                next     = d.lw ? WB : FETCH;
            end
            WB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            default: next = FETCH;
        endcase
        InsnDone = next == FETCH;
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Illegal  = 1'b0;
            InsnDone = 1'b0;
            EXTOp    = EXT_ZERO;
            ALUOp    = ALU_NOP;
            BSel     = 1'b0;
            NPCOp    = NPC_PLUS4;
            GPRSel   = GPRSEL_RD;
            WDSel    = WDSEL_ALU;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed walk through every instruction class with hand-computed control values
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, BSel, InsnDone, Illegal;
    logic [1:0] EXTOp, NPCOp, GPRSel, WDSel;
    logic [2:0] ALUOp;
    logic [5:0] en;
    int         n_cmp = 0;
    int         n_bad = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .EXTOp(EXTOp), .ALUOp(ALUOp), .BSel(BSel), .NPCOp(NPCOp),
        .GPRSel(GPRSel), .WDSel(WDSel), .InsnDone(InsnDone), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // {PCWrite, IRWrite, RegWrite, MemWrite, InsnDone, Illegal}
    assign en = {PCWrite, IRWrite, RegWrite, MemWrite, InsnDone, Illegal};

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; Op = 6'b100011; Funct = 6'b0; Zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_en", int'(en), 'b000000);
            chk("rst_ext", int'(EXTOp), 0);
            chk("rst_alu", int'(ALUOp), 0);
        end
        rst = 1'b0; #1;
        chk("lw_fetch_en", int'(en), 'b110000);
        chk("lw_fetch_npc", int'(NPCOp), 0);
        chk("lw_fetch_ext", int'(EXTOp), 1);
        cyc();
        chk("lw_dcd_en", int'(en), 'b000000);
        chk("lw_dcd_ext", int'(EXTOp), 1);
        cyc();
        chk("lw_exe_en", int'(en), 'b000000);
        chk("lw_exe_alu", int'(ALUOp), 1);
        chk("lw_exe_bsel", int'(BSel), 1);
        cyc();
        chk("lw_mem_en", int'(en), 'b000000);
        chk("lw_mem_alu", int'(ALUOp), 1);
        cyc();
        chk("lw_wb_en", int'(en), 'b001010);
        chk("lw_wb_wd", int'(WDSel), 1);
        chk("lw_wb_gpr", int'(GPRSel), 1);
        chk("lw_wb_ext", int'(EXTOp), 1);
        cyc();
        Op = 6'b000100; Zero = 1'b1; #1;
        chk("beq1_fetch_en", int'(en), 'b110000);
        cyc();
        chk("beq1_dcd_en", int'(en), 'b000000);
        cyc();
        chk("beq1_exe_en", int'(en), 'b100010);
        chk("beq1_exe_npc", int'(NPCOp), 1);
        chk("beq1_exe_alu", int'(ALUOp), 2);
        chk("beq1_exe_bsel", int'(BSel), 0);
        cyc();
        Zero = 1'b0; #1;
        chk("beq0_fetch_en", int'(en), 'b110000);
        cyc();
        cyc();
        chk("beq0_exe_en", int'(en), 'b000010);
        chk("beq0_exe_npc", int'(NPCOp), 1);
        cyc();
        Op = 6'b000101; #1;
        chk("bne_fetch_en", int'(en), 'b110000);
        cyc();
        cyc();
        chk("bne_exe_en", int'(en), 'b100010);
        cyc();
        Op = 6'b001111; #1;
        chk("lui_fetch_en", int'(en), 'b110000);
        chk("lui_ext", int'(EXTOp), 2);
        cyc();
        cyc();
        chk("lui_exe_alu", int'(ALUOp), 1);
        chk("lui_exe_bsel", int'(BSel), 1);
        chk("lui_exe_en", int'(en), 'b000000);
        cyc();
        chk("lui_wb_en", int'(en), 'b001010);
        chk("lui_wb_gpr", int'(GPRSel), 1);
        chk("lui_wb_wd", int'(WDSel), 0);
        cyc();
        Op = 6'b001101; #1;
        chk("ori_fetch_en", int'(en), 'b110000);
        chk("ori_ext", int'(EXTOp), 0);
        cyc();
        cyc();
        chk("ori_exe_alu", int'(ALUOp), 4);
        cyc();
        chk("ori_wb_en", int'(en), 'b001010);
        cyc();
        Op = 6'b000000; Funct = 6'b100011; #1;
        chk("subu_fetch_en", int'(en), 'b110000);
        cyc();
        cyc();
        chk("subu_exe_alu", int'(ALUOp), 2);
        chk("subu_exe_bsel", int'(BSel), 0);
        cyc();
        chk("subu_wb_en", int'(en), 'b001010);
        chk("subu_wb_gpr", int'(GPRSel), 0);
        cyc();
        Op = 6'b000011; #1;
        chk("jal_fetch_en", int'(en), 'b110000);
        cyc();
        chk("jal_dcd_en", int'(en), 'b101010);
        chk("jal_dcd_npc", int'(NPCOp), 2);
        chk("jal_dcd_gpr", int'(GPRSel), 2);
        chk("jal_dcd_wd", int'(WDSel), 2);
        cyc();
        Op = 6'b000000; Funct = 6'b001000; #1;
        chk("jr_fetch_en", int'(en), 'b110000);
        cyc();
        chk("jr_dcd_en", int'(en), 'b100010);
        chk("jr_dcd_npc", int'(NPCOp), 3);
        cyc();
        Op = 6'b111111; #1;
        chk("ill_fetch_en", int'(en), 'b110000);
        cyc();
        chk("ill_dcd_en", int'(en), 'b000011);
        cyc();
        Op = 6'b101011; #1;
        chk("sw_fetch_en", int'(en), 'b110000);
        cyc();
        cyc();
        chk("sw_exe_alu", int'(ALUOp), 1);
        chk("sw_exe_bsel", int'(BSel), 1);
        cyc();
        chk("sw_mem_en", int'(en), 'b000110);
        cyc();
        chk("sw2_fetch_en", int'(en), 'b110000);
        cyc();
        cyc();
        @(negedge clk);
        rst = 1'b1; #1;
        chk("sw2_rstmem_en", int'(en), 'b000000);
        chk("sw2_rstmem_ext", int'(EXTOp), 0);
        cyc();
        chk("sw2_rsthold_en", int'(en), 'b000000);
        rst = 1'b0; #1;
        chk("sw2_rel_fetch_en", int'(en), 'b110000);
        cyc();
        chk("sw2_rel_dcd_en", int'(en), 'b000000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
